// File: rtl/fifo_defs.sv
// rtl/fifo_defs.sv - shared widths, helpers and default sizing for the RS232 byte FIFOs
package fifo_defs;

  localparam int DEF_FIFO_DEPTH         = 16;
  localparam int DEF_DATA_WIDTH         = 8;
  localparam int DEF_ALMOST_FULL_LEVEL  = DEF_FIFO_DEPTH - 2;
  localparam int DEF_ALMOST_EMPTY_LEVEL = 2;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) result++;
    return result;
  endfunction

  // count must represent FIFO_DEPTH itself, hence depth+1
  function automatic int count_width(input int depth);
    return clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - register array, one synchronous write port, one asynchronous read port
module fifo_mem
  import fifo_defs::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                            clk_i,
  input  logic                            wr_en_i,
  input  logic [ptr_width(FIFO_DEPTH)-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0]           wr_data_i,
  input  logic [ptr_width(FIFO_DEPTH)-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0]           rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  // No reset: stale entries are hidden by the output mask in sync_fifo
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock first-word-fall-through FIFO with count, thresholds and sticky error flags
module sync_fifo
  import fifo_defs::*;
#(
  parameter int FIFO_DEPTH         = DEF_FIFO_DEPTH,
  parameter int DATA_WIDTH         = DEF_DATA_WIDTH,
  parameter int ALMOST_FULL_LEVEL  = FIFO_DEPTH - 2,
  parameter int ALMOST_EMPTY_LEVEL = DEF_ALMOST_EMPTY_LEVEL
) (
  input  logic                              clock,
  input  logic                              clear,
  input  logic                              enable,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH-1:0]             in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic [count_width(FIFO_DEPTH)-1:0] count,
  output logic                              full,
  output logic                              empty,
  output logic                              almost_full,
  output logic                              almost_empty,
  output logic                              overflow,
  output logic                              underflow
);

  localparam int              CW        = count_width(FIFO_DEPTH);
  localparam int              AW        = ptr_width(FIFO_DEPTH);
  localparam logic [AW-1:0]   LAST_PTR  = AW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0]   DEPTH_CNT = CW'(FIFO_DEPTH);

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic                  active, push, pop;
  logic [DATA_WIDTH-1:0] rd_data;

  // Explicit wrap so non-power-of-two depths work
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + AW'(1);
  endfunction

  assign active       = enable & ~flush;
  assign full         = (count_q == DEPTH_CNT);
  assign empty        = (count_q == '0);
  assign almost_full  = (int'(count_q) >= ALMOST_FULL_LEVEL);
  assign almost_empty = (int'(count_q) <= ALMOST_EMPTY_LEVEL);
  assign in_ready     = active & ~full;
  assign out_valid    = active & ~empty;
  assign push         = in_valid & in_ready;
  assign pop          = out_valid & out_ready;
  assign out_data     = out_valid ? rd_data : '0;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (enable) begin
      if (push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (in_valid & full)   overflow_d  = 1'b1;
      if (out_ready & empty) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mem (
    .clk_i    (clock),
    .wr_en_i  (push & ~clear),
    .wr_addr_i(wr_ptr_q),
    .wr_data_i(in_data),
    .rd_addr_i(rd_ptr_q),
    .rd_data_o(rd_data)
  );

endmodule
